nubus_video_fetch: RTL and testbench

- Parametrised scan-out fetch engine for NuBus video cards.
- Prefetches framebuffer words from SDRAM into a FIFO and unpacks them into 1/2/4/8-bpp CLUT indices at pixel rate.
- Supports a programmable base address, a programmable line stride and arbitrary active resolution.
- Sits between the card's register file/timing generator and the SDRAM arbiter; output feeds the CLUT.

---
 rtl/nubus_video_pkg.sv | 61 ++++++
 rtl/nubus_video_fetch_if.sv | 23 ++
 rtl/nubus_video_fifo.sv | 58 +++++
 rtl/nubus_video_fetch.sv | 196 +++++++++++++++++++
 tb/tb_nubus_video_fetch.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nubus_video_pkg.sv
// ============================================================================
// Module : nubus_video_pkg
// Purpose: Shared types and helpers for the NuBus video scan-out fetch path:
//          colour-depth encoding, fetch FSM state encoding, and the
//          bits-per-pixel / pixels-per-word / words-per-line / unpack helpers.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nubus_video_pkg;

  // Colour depth select; bpp = 1 << mode.
  typedef enum logic [1:0] {
    MODE_1BPP = 2'd0,
    MODE_2BPP = 2'd1,
    MODE_4BPP = 2'd2,
    MODE_8BPP = 2'd3
  } mode_e;

  // Fetch FSM state encoding.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

  function automatic logic [3:0] bpp_of(input mode_e m);
    return 4'd1 << m;
  endfunction

  // Pixels held in one 16-bit framebuffer word.
  function automatic logic [4:0] ppw_of(input mode_e m);
    return 5'd16 >> m;
  endfunction

  // Framebuffer words needed for one active line.
  function automatic logic [15:0] wpl_of(input mode_e m, input int unsigned h_res);
    return 16'((h_res * 32'(bpp_of(m))) / 32'd16);
  endfunction

  // Leftmost (MSB-first) pixel of a word, zero-extended to a CLUT index.
  function automatic logic [7:0] pixel_of(input logic [15:0] w, input mode_e m);
    logic [7:0] p;
    p = w[15:8];
    case (m)
      MODE_1BPP: p = {7'd0, w[15]};
      MODE_2BPP: p = {6'd0, w[15:14]};
      MODE_4BPP: p = {4'd0, w[15:12]};
      default:   p = w[15:8];
    endcase
    return p;
  endfunction

  // Drop the leftmost pixel of a word.
  function automatic logic [15:0] shift_of(input logic [15:0] w, input mode_e m);
    return w << bpp_of(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/nubus_video_fetch_if.sv
// ============================================================================
// Module : nubus_video_fetch_if
// Purpose: SDRAM read-request channel between the scan-out fetch engine
//          (master) and the SDRAM arbiter (slave). One request outstanding;
//          mem_req is held until mem_ack, mem_rdata valid with mem_ack.
// Ports  : mem_req, mem_addr[ADDR_W], mem_ack, mem_rdata[16]
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface nubus_video_fetch_if #(
  parameter int ADDR_W = 25
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

`default_nettype wire

// File: rtl/nubus_video_fifo.sv
// ============================================================================
// Module : nubus_video_fifo
// Purpose: Synchronous show-ahead FIFO for prefetched framebuffer words.
//          flush empties it in one cycle. Push on a full FIFO is accepted only
//          together with a pop (count unchanged); pop on empty is ignored.
// Ports  : clk, reset, flush, push, din[WIDTH], pop, dout[WIDTH],
//          count[clog2(DEPTH)+1], empty
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nubus_video_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (int'(count) == DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

`default_nettype wire

// File: rtl/nubus_video_fetch.sv
// ============================================================================
// Module : nubus_video_fetch
// Purpose: Scan-out fetch engine. Prefetches framebuffer words from SDRAM into
//          a FIFO and unpacks them MSB-first into 1/2/4/8-bpp CLUT indices.
// Ports  : clk, reset (sync, active-high)
//          cfg_enable, cfg_mode[2], cfg_base[ADDR_W], cfg_stride[16]
//          frame_start, line_start, pix_rd
//          mem (nubus_video_fetch_if.master): mem_req/mem_addr/mem_ack/mem_rdata
//          pix_idx[8], pix_valid, underflow (sticky)
//          cfg_hpan[4]  only with NUBUS_VIDEO_FETCH_PAN_EN
// Config : `define NUBUS_VIDEO_FETCH_PAN_EN adds horizontal pixel panning.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nubus_video_fetch
  import nubus_video_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 25,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_enable,
  input  logic [1:0]        cfg_mode,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [15:0]       cfg_stride,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              pix_rd,
`ifdef NUBUS_VIDEO_FETCH_PAN_EN
  input  logic [3:0]        cfg_hpan,
`endif
  nubus_video_fetch_if.master mem,
  output logic [7:0]        pix_idx,
  output logic              pix_valid,
  output logic              underflow
);
  localparam logic [0:0] IDLE = ST_IDLE;
  localparam logic [0:0] REQ  = ST_REQ;
  localparam int LN_W = $clog2(V_RES + 1);

  logic [0:0]              state;
  logic [ADDR_W-1:0]       line_base, fetch_ptr, req_addr, base_now;
  logic [15:0]             words_left;
  logic                    flush_pending;
  mode_e                   mode_q;
  logic [LN_W-1:0]         line_cnt;
  logic [15:0]             shreg;
  logic [4:0]              pix_left;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [15:0]             fifo_dout;
  logic                    fifo_empty;
  logic                    line_go, flush, stale, ack_ok;
  logic                    can_issue, can_continue;
  logic                    have, can_take, take, deliver, skipping, hpan_nz;
  logic [15:0]             src;

  // Lines beyond V_RES in a frame are ignored entirely.
  assign line_go  = line_start && (frame_start || int'(line_cnt) < V_RES);
  assign flush    = frame_start || line_go;
  assign base_now = frame_start ? cfg_base : line_base;

  // An ack that coincides with or follows a flush belongs to the old line.
  assign stale  = flush || flush_pending;
  assign ack_ok = (state == REQ) && mem.mem_ack && !stale;

  // Start only below the low-water mark; once running, keep going while the
  // word being acked still leaves room for another one (fill to full).
  assign can_issue = cfg_enable && !flush && (words_left != 16'd0) &&
                     (int'(fifo_count) < LOW_WATER) &&
                     (int'(fifo_count) + 1 <= FIFO_DEPTH);
  assign can_continue = cfg_enable && !flush && (words_left > 16'd1) &&
                        (int'(fifo_count) + 2 <= FIFO_DEPTH);

  assign mem.mem_req  = (state == REQ);
  assign mem.mem_addr = req_addr;

  nubus_video_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (ack_ok),
    .din   (mem.mem_rdata),
    .pop   (take && !have),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      line_base     <= '0;
      fetch_ptr     <= '0;
      req_addr      <= '0;
      words_left    <= '0;
      flush_pending <= 1'b0;
      mode_q        <= MODE_1BPP;
      line_cnt      <= '0;
    end else begin
      if (frame_start) begin
        line_base <= cfg_base;
        line_cnt  <= '0;
      end
      if (line_go) begin
        fetch_ptr  <= base_now;
        words_left <= wpl_of(mode_e'(cfg_mode), H_RES) + {15'd0, hpan_nz};
        line_base  <= base_now + ADDR_W'(cfg_stride);
        mode_q     <= mode_e'(cfg_mode);
        line_cnt   <= frame_start ? LN_W'(1) : line_cnt + LN_W'(1);
      end else if (ack_ok) begin
        fetch_ptr  <= fetch_ptr + ADDR_W'(1);
        words_left <= words_left - 16'd1;
      end

      case (state)
        IDLE: begin
          if (can_issue) begin
            state    <= REQ;
            req_addr <= fetch_ptr;
          end
        end
        default: begin
          // Address is never changed while the request is pending.
          if (mem.mem_ack) begin
            flush_pending <= 1'b0;
            if (!stale && can_continue) req_addr <= fetch_ptr + ADDR_W'(1);
            else                        state    <= IDLE;
          end else if (flush) begin
            flush_pending <= 1'b1;
          end
        end
      endcase
    end
  end

  // Unpacker: the current pixel comes from the shifter while it holds pixels,
  // otherwise straight from the FIFO head so a reload costs no cycle.
  assign have     = (pix_left != 5'd0);
  assign src      = have ? shreg : fifo_dout;
  assign can_take = have || !fifo_empty;
  assign take     = cfg_enable && !flush && can_take && (skipping || pix_rd);
  assign deliver  = take && !skipping;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '0;
      pix_left  <= '0;
      pix_idx   <= '0;
      pix_valid <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        shreg    <= '0;
        pix_left <= '0;
      end else if (take) begin
        shreg    <= shift_of(src, mode_q);
        pix_left <= (have ? pix_left : ppw_of(mode_q)) - 5'd1;
      end

      if (pix_rd) begin
        pix_idx   <= deliver ? pixel_of(src, mode_q) : 8'd0;
        pix_valid <= deliver;
      end else begin
        pix_valid <= 1'b0;
      end

      if (frame_start)                                    underflow <= 1'b0;
      else if (pix_rd && cfg_enable && !flush && !deliver) underflow <= 1'b1;
    end
  end

`ifdef NUBUS_VIDEO_FETCH_PAN_EN
  // Leading pixels are discarded as soon as they arrive; a pix_rd during the
  // skip gets no pixel.
  logic [3:0] skip_cnt;
  assign skipping = (skip_cnt != 4'd0);
  assign hpan_nz  = (cfg_hpan != 4'd0);

  always_ff @(posedge clk) begin
    if (reset)                 skip_cnt <= '0;
    else if (line_go)          skip_cnt <= cfg_hpan;
    else if (take && skipping) skip_cnt <= skip_cnt - 4'd1;
  end
`else
  assign skipping = 1'b0;
  assign hpan_nz  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nubus_video_fetch.sv
// ============================================================================
// Module : tb_nubus_video_fetch
// Purpose: Directed self-checking bench for nubus_video_fetch. An SDRAM model
//          answers requests after a programmable delay with a scrambled
//          function of the address (or a constant pattern).
// Ports  : none
// Config : NUBUS_VIDEO_FETCH_PAN_EN enables the panning scenario.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nubus_video_fetch;
  localparam int ADDR_W = 25;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_enable;
  logic [1:0]        cfg_mode;
  logic [ADDR_W-1:0] cfg_base;
  logic [15:0]       cfg_stride;
  logic              frame_start;
  logic              line_start;
  logic              pix_rd;
  logic [7:0]        pix_idx;
  logic              pix_valid;
  logic              underflow;
`ifdef NUBUS_VIDEO_FETCH_PAN_EN
  logic [3:0]        cfg_hpan;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int  ack_delay = 0;
  int  wait_cnt  = 0;
  logic const_pat = 1'b0;

  logic [ADDR_W-1:0] fetch_q[$];
  logic [7:0]        got_idx[$];
  logic              got_valid[$];

  always #5 clk = ~clk;

  nubus_video_fetch_if #(.ADDR_W(ADDR_W)) mem_if ();

  function automatic logic [15:0] scramble(input logic [ADDR_W-1:0] a);
    return 16'(a[15:0] * 16'd40503) + 16'h1D2B;
  endfunction

  // Expected byte k of an 8-bpp line starting at word address base.
  function automatic logic [7:0] byte_at(input logic [ADDR_W-1:0] base, input int k);
    logic [15:0] w;
    w = scramble(base + ADDR_W'(k / 2));
    return (k % 2 == 1) ? w[7:0] : w[15:8];
  endfunction

  assign mem_if.mem_ack   = mem_if.mem_req && (ack_delay == 0 || wait_cnt == ack_delay);
  assign mem_if.mem_rdata = const_pat ? 16'hA5F0 : scramble(mem_if.mem_addr);

  always @(posedge clk) begin
    if (!mem_if.mem_req || mem_if.mem_ack) wait_cnt <= 0;
    else                                   wait_cnt <= wait_cnt + 1;
    if (mem_if.mem_req && mem_if.mem_ack) fetch_q.push_back(mem_if.mem_addr);
  end

  nubus_video_fetch #(
    .H_RES(640), .V_RES(480), .ADDR_W(ADDR_W), .FIFO_DEPTH(16), .LOW_WATER(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_enable  (cfg_enable),
    .cfg_mode    (cfg_mode),
    .cfg_base    (cfg_base),
    .cfg_stride  (cfg_stride),
    .frame_start (frame_start),
    .line_start  (line_start),
    .pix_rd      (pix_rd),
`ifdef NUBUS_VIDEO_FETCH_PAN_EN
    .cfg_hpan    (cfg_hpan),
`endif
    .mem         (mem_if),
    .pix_idx     (pix_idx),
    .pix_valid   (pix_valid),
    .underflow   (underflow)
  );

  // All helpers start and end on a falling edge.
  task automatic pulse(input logic fs, input logic ls);
    frame_start = fs;
    line_start  = ls;
    @(negedge clk);
    frame_start = 1'b0;
    line_start  = 1'b0;
  endtask

  task automatic settle();
    pix_rd     = 1'b0;
    ack_delay  = 0;
    cfg_enable = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic read_pixels(input int n);
    got_idx.delete();
    got_valid.delete();
    for (int i = 0; i < n; i++) begin
      pix_rd = 1'b1;
      @(negedge clk);
      got_idx.push_back(pix_idx);
      got_valid.push_back(pix_valid);
    end
    pix_rd = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_enable = 1'b0; cfg_mode = 2'd0; cfg_base = '0;
    cfg_stride = '0; frame_start = 1'b0; line_start = 1'b0; pix_rd = 1'b0;
`ifdef NUBUS_VIDEO_FETCH_PAN_EN
    cfg_hpan = 4'd0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_if.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_if.mem_req); end
    n_checks++; if (mem_if.mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_if.mem_addr); end
    n_checks++; if (pix_idx !== 8'd0) begin n_fail++; $display("FAIL reset_pix_idx: got %h want 0", pix_idx); end
    n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid: got %b want 0", pix_valid); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b want 0", underflow); end
  endtask

  task automatic test_line_8bpp();
    int bad, first_bad;
    settle();
    cfg_mode = 2'd3; cfg_base = 25'h1000; cfg_stride = 16'd320; cfg_enable = 1'b1;
    fetch_q.delete();
    pulse(1'b1, 1'b1);
    repeat (40) @(negedge clk);
    read_pixels(640);
    repeat (10) @(negedge clk);
    bad = 0; first_bad = 0;
    for (int k = 0; k < 640; k++)
      if (got_idx[k] !== byte_at(25'h1000, k) || got_valid[k] !== 1'b1) begin
        if (bad == 0) first_bad = k;
        bad++;
      end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL line8_pixels: %0d bad, first at %0d got %h/%b want %h/1", bad, first_bad, got_idx[first_bad], got_valid[first_bad], byte_at(25'h1000, first_bad)); end
    n_checks++; if (fetch_q.size() != 320) begin n_fail++; $display("FAIL line8_fetch_count: got %0d want 320", fetch_q.size()); end
    n_checks++; if (fetch_q.size() == 0 || fetch_q[0] !== 25'h1000) begin n_fail++; $display("FAIL line8_first_addr: want 1000"); end
    n_checks++; if (fetch_q.size() != 320 || fetch_q[319] !== 25'h113F) begin n_fail++; $display("FAIL line8_last_addr: want 113f"); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL line8_underflow: got %b want 0", underflow); end
  endtask

  task automatic test_mode_1bpp();
    logic [15:0] pat;
    logic [7:0]  exp;
    pat = 16'hA5F0;
    settle();
    const_pat = 1'b1;
    cfg_mode = 2'd0; cfg_base = '0; cfg_stride = 16'd40; cfg_enable = 1'b1;
    pulse(1'b1, 1'b1);
    repeat (20) @(negedge clk);
    read_pixels(32);
    for (int k = 0; k < 32; k++) begin
      exp = {7'd0, pat[15 - (k % 16)]};
      n_checks++;
      if (got_idx[k] !== exp || got_valid[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL mode1_pix%0d: got %h/%b want %h/1", k, got_idx[k], got_valid[k], exp);
      end
    end
    const_pat = 1'b0;
  endtask

  task automatic test_underflow();
    int n_inv, bad, j;
    settle();
    ack_delay = 20;
    cfg_mode = 2'd3; cfg_base = 25'h4000; cfg_stride = 16'd320; cfg_enable = 1'b1;
    pulse(1'b1, 1'b1);
    repeat (2) @(negedge clk);
    read_pixels(60);
    n_inv = 0; bad = 0; j = 0;
    for (int k = 0; k < 60; k++) begin
      if (got_valid[k] === 1'b1) begin
        if (got_idx[k] !== byte_at(25'h4000, j)) bad++;
        j++;
      end else begin
        n_inv++;
        if (got_idx[k] !== 8'd0) bad++;
      end
    end
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL uf_flag: got %b want 1", underflow); end
    n_checks++; if (n_inv == 0) begin n_fail++; $display("FAIL uf_invalid_seen: got 0 invalid pixels want >0"); end
    n_checks++; if (j == 0) begin n_fail++; $display("FAIL uf_valid_seen: got 0 valid pixels want >0"); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL uf_pixel_values: %0d bad want 0", bad); end
    pulse(1'b1, 1'b0);
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL uf_cleared: got %b want 0", underflow); end
  endtask

  task automatic test_disabled();
    int bad;
    settle();
    cfg_mode = 2'd3; cfg_base = 25'h5000;
    pulse(1'b1, 1'b1);
    repeat (10) @(negedge clk);
    n_checks++; if (mem_if.mem_req !== 1'b0) begin n_fail++; $display("FAIL dis_no_fetch: got req %b want 0", mem_if.mem_req); end
    read_pixels(4);
    bad = 0;
    for (int k = 0; k < 4; k++) if (got_idx[k] !== 8'd0 || got_valid[k] !== 1'b0) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL dis_pixels: %0d non-zero/valid want 0", bad); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL dis_underflow: got %b want 0", underflow); end
  endtask

  task automatic test_stride(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] e0,
                             input logic [ADDR_W-1:0] e1, input logic [ADDR_W-1:0] e2);
    logic [ADDR_W-1:0] exp [3];
    exp[0] = e0; exp[1] = e1; exp[2] = e2;
    settle();
    cfg_mode = 2'd3; cfg_base = base; cfg_stride = 16'd512; cfg_enable = 1'b1;
    for (int l = 0; l < 3; l++) begin
      fetch_q.delete();
      pulse(l == 0, 1'b1);
      repeat (40) @(negedge clk);
      n_checks++;
      if (fetch_q.size() == 0 || fetch_q[0] !== exp[l]) begin
        n_fail++;
        $display("FAIL stride_line%0d_addr: got %h want %h", l, (fetch_q.size() == 0) ? '0 : fetch_q[0], exp[l]);
      end
    end
  endtask

  task automatic test_flush_in_req();
    int t;
    settle();
    ack_delay = 10;
    cfg_mode = 2'd3; cfg_base = 25'h3000; cfg_stride = 16'h0100; cfg_enable = 1'b1;
    pulse(1'b1, 1'b1);
    t = 0;
    while (mem_if.mem_req !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    n_checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 25'h3000) begin n_fail++; $display("FAIL flush_first_req: got req %b addr %h want 1/3000", mem_if.mem_req, mem_if.mem_addr); end
    repeat (3) @(negedge clk);
    pulse(1'b0, 1'b1);
    n_checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 25'h3000) begin n_fail++; $display("FAIL flush_req_held: got req %b addr %h want 1/3000", mem_if.mem_req, mem_if.mem_addr); end
    t = 0;
    while (mem_if.mem_req !== 1'b0 && t < 30) begin @(negedge clk); t++; end
    while (mem_if.mem_req !== 1'b1 && t < 60) begin @(negedge clk); t++; end
    n_checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 25'h3100) begin n_fail++; $display("FAIL flush_new_addr: got req %b addr %h want 1/3100", mem_if.mem_req, mem_if.mem_addr); end
    repeat (40) @(negedge clk);
    read_pixels(1);
    n_checks++; if (got_idx[0] !== byte_at(25'h3100, 0) || got_valid[0] !== 1'b1) begin n_fail++; $display("FAIL flush_stale_dropped: got %h/%b want %h/1", got_idx[0], got_valid[0], byte_at(25'h3100, 0)); end
  endtask

`ifdef NUBUS_VIDEO_FETCH_PAN_EN
  task automatic test_pan();
    int bad;
    settle();
    cfg_mode = 2'd3; cfg_base = 25'h6000; cfg_stride = 16'd321; cfg_hpan = 4'd3; cfg_enable = 1'b1;
    fetch_q.delete();
    pulse(1'b1, 1'b1);
    repeat (40) @(negedge clk);
    read_pixels(639);
    repeat (10) @(negedge clk);
    n_checks++; if (got_idx[0] !== byte_at(25'h6000, 3) || got_valid[0] !== 1'b1) begin n_fail++; $display("FAIL pan_first_pixel: got %h/%b want %h/1", got_idx[0], got_valid[0], byte_at(25'h6000, 3)); end
    bad = 0;
    for (int k = 0; k < 639; k++)
      if (got_idx[k] !== byte_at(25'h6000, k + 3) || got_valid[k] !== 1'b1) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL pan_pixels: %0d bad want 0", bad); end
    n_checks++; if (fetch_q.size() != 321) begin n_fail++; $display("FAIL pan_wpl: got %0d words want 321", fetch_q.size()); end
    cfg_hpan = 4'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_line_8bpp();
    test_mode_1bpp();
    test_underflow();
    test_disabled();
    test_stride(25'h0002000, 25'h0002000, 25'h0002200, 25'h0002400);
    test_stride(25'h1FFFF9C, 25'h1FFFF9C, 25'h000019C, 25'h000039C);
    test_flush_in_req();
`ifdef NUBUS_VIDEO_FETCH_PAN_EN
    test_pan();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
